// File: rtl/crc5_frame_tx.sv
// Gen2 reader-side short-command serializer: payload MSB-first, then CRC5 (x^5+x^3+1) MSB-first.
// One frame bit per bit_tick_i, visible one clock after the tick; start_i is ignored while busy.
module crc5_frame_tx #(
    parameter int         DATA_W     = 32,
    parameter int         LEN_W      = 6,
    parameter logic [4:0] CRC_PRESET = 5'b01001
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [LEN_W-1:0]  data_len_i,
    input  logic              bit_tick_i,
    output logic              busy_o,
    output logic              txbit_o,
    output logic              txbit_valid_o,
    output logic              done_o,
    output logic [4:0]        crc_out_o
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;

    localparam logic [LEN_W-1:0] DATA_W_L = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] CRC_LAST = LEN_W'(4);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         crc_q, crc_d;
    logic [4:0]         crc_out_q, crc_out_d;
    logic               txbit_q, txbit_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   len;
    logic               fb;
    logic [4:0]         crc_upd;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            crc_q     <= '0;
            crc_out_q <= '0;
            txbit_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            txbit_q   <= txbit_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // Payload is left-aligned at start so the next bit is always data_q MSB.
    always_comb begin
        len     = (data_len_i > DATA_W_L) ? DATA_W_L : data_len_i;
        fb      = data_q[DATA_W-1] ^ crc_q[4];
        crc_upd = {crc_q[3], crc_q[2] ^ fb, crc_q[1], crc_q[0], fb};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = (len == '0) ? S_CRC : S_DATA;
            S_DATA:  if (bit_tick_i && cnt_q == '0) state_d = S_CRC;
            S_CRC:   if (bit_tick_i && cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        txbit_d   = txbit_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    data_d = data_in_i << (DATA_W_L - len);
                    crc_d  = CRC_PRESET;
                    if (len == '0) begin
                        cnt_d     = CRC_LAST;
                        crc_out_d = CRC_PRESET;
                    end else begin
                        cnt_d = len - LEN_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (bit_tick_i) begin
                    txbit_d = data_q[DATA_W-1];
                    valid_d = 1'b1;
                    data_d  = data_q << 1;
                    crc_d   = crc_upd;
                    if (cnt_q == '0) begin
                        crc_out_d = crc_upd;
                        cnt_d     = CRC_LAST;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            S_CRC: begin
                if (bit_tick_i) begin
                    txbit_d = crc_q[4];
                    valid_d = 1'b1;
                    crc_d   = {crc_q[3:0], 1'b0};
                    if (cnt_q == '0) done_d = 1'b1;
                    else             cnt_d  = cnt_q - LEN_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o        = (state_q != S_IDLE);
        txbit_o       = txbit_q;
        txbit_valid_o = valid_q;
        done_o        = done_q;
        crc_out_o     = crc_out_q;
    end

endmodule
